// File: rtl/ecc_scrub_arbiter.sv
// Data-memory port arbiter: the pipeline always wins; idle cycles feed a background ECC scrubber.
// Optional macro ECC_SCRUB_LOG_EN keeps the corr_cnt / last_err_addr logging registers.
module ecc_scrub_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_s_err,
    input  logic              mem_d_err,
    output logic              scrub_busy,
    output logic              sweep_done,
    output logic              uncorr_flag,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [ADDR_W-1:0] last_err_addr
);
    localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [IW-1:0] IV_LAST = IW'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {WAIT, READ, WB} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     iv_cnt, iv_cnt_nx;
    logic [ADDR_W-1:0] scrub_addr;
    logic [31:0]       wb_data;
    logic              cpu_act, advance, latch_wb, log_unc;

    assign cpu_act    = cpu_re | cpu_we;
    assign cpu_rdata  = mem_rdata;
    assign scrub_busy = (state != WAIT);
    // Write-back is masked while rst is low so a pending repair never reaches memory.
    assign mem_we     = cpu_act ? cpu_we : (rst && state == WB);
    assign mem_addr   = cpu_act ? cpu_addr : scrub_addr;
    assign mem_wdata  = cpu_act ? cpu_wdata : wb_data;

    always_comb begin
        state_nx  = state;
        iv_cnt_nx = iv_cnt;
        advance   = 1'b0;
        latch_wb  = 1'b0;
        log_unc   = 1'b0;
        case (state)
            WAIT: begin
                if (scrub_en) begin
                    if (iv_cnt == IV_LAST) begin
                        iv_cnt_nx = '0;
                        state_nx  = READ;
                    end else begin
                        iv_cnt_nx = iv_cnt + 1'b1;
                    end
                end
            end
            READ: begin
                if (!cpu_act) begin
                    // d_err dominates when both error flags are raised
                    if (mem_d_err) begin
                        log_unc  = 1'b1;
                        advance  = 1'b1;
                        state_nx = WAIT;
                    end else if (mem_s_err) begin
                        latch_wb = 1'b1;
                        state_nx = WB;
                    end else begin
                        advance  = 1'b1;
                        state_nx = WAIT;
                    end
                end
            end
            WB: begin
                // A CPU store to the same word carries newer data: drop the repair.
                if (cpu_we && cpu_addr == scrub_addr) begin
                    advance  = 1'b1;
                    state_nx = WAIT;
                end else if (!cpu_act) begin
                    advance  = 1'b1;
                    state_nx = WAIT;
                end
            end
            default: state_nx = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= WAIT;
            iv_cnt      <= '0;
            scrub_addr  <= '0;
            wb_data     <= '0;
            uncorr_flag <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            iv_cnt     <= iv_cnt_nx;
            sweep_done <= advance && (scrub_addr == '1);
            if (advance)  scrub_addr  <= scrub_addr + 1'b1;
            if (latch_wb) wb_data     <= mem_rdata;
            if (log_unc)  uncorr_flag <= 1'b1;
        end
    end

`ifdef ECC_SCRUB_LOG_EN
    logic              log_corr;
    logic [CNT_W-1:0]  corr_q;
    logic [ADDR_W-1:0] last_q;

    // A cancelled write-back always has cpu_act high, so it never logs.
    assign log_corr = (state == WB) && !cpu_act;

    always_ff @(posedge clk) begin
        if (!rst) begin
            corr_q <= '0;
            last_q <= '0;
        end else begin
            if (log_corr && corr_q != '1) corr_q <= corr_q + 1'b1;
            if (log_corr || log_unc)      last_q <= scrub_addr;
        end
    end

    assign corr_cnt      = corr_q;
    assign last_err_addr = last_q;
`else
    assign corr_cnt      = '0;
    assign last_err_addr = '0;
`endif

endmodule

// File: tb/tb_ecc_scrub_arbiter.sv
// Bench for ecc_scrub_arbiter: ECC memory model, transaction-level scrubber model, directed + random tasks.
module tb_ecc_scrub_arbiter;
    localparam int AW = 3, IV = 4, CW = 8;
    localparam int DEPTH = 1 << AW;
`ifdef ECC_SCRUB_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b0, scrub_en = 1'b0, cpu_re = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata, mem_wdata, mem_rdata;
    logic          mem_we, mem_s_err, mem_d_err, scrub_busy, sweep_done, uncorr_flag;
    logic [AW-1:0] mem_addr, last_err_addr;
    logic [CW-1:0] corr_cnt;

    int checks = 0, errors = 0;

    ecc_scrub_arbiter #(.ADDR_W(AW), .SCRUB_INTERVAL(IV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_s_err(mem_s_err), .mem_d_err(mem_d_err), .scrub_busy(scrub_busy),
        .sweep_done(sweep_done), .uncorr_flag(uncorr_flag), .corr_cnt(corr_cnt),
        .last_err_addr(last_err_addr)
    );

    always #5 clk = ~clk;

    // ECC memory: golden holds the true word, flip the injected bit errors on top of it.
    logic [31:0]   golden [DEPTH];
    logic [31:0]   flip   [DEPTH];
    logic          ld = 1'b0, inj = 1'b0;
    logic [AW-1:0] inj_a = '0;
    logic [31:0]   inj_m = '0;
    int            wr_count = 0;

    function automatic logic [31:0] pat(int i);
        return 32'h5A5A_0000 ^ (32'(i + 1) * 32'h0101_0101);
    endfunction

    function automatic logic [31:0] view(logic [AW-1:0] a);
        return ($countones(flip[a]) > 1) ? (golden[a] ^ flip[a]) : golden[a];
    endfunction

    always_comb begin
        mem_rdata = view(mem_addr);
        mem_s_err = ($countones(flip[mem_addr]) == 1);
        mem_d_err = ($countones(flip[mem_addr]) > 1);
    end

    // Reference model: "a word is due" after IV enabled cycles, then it is checked on the
    // first idle port cycle and, if singly corrupted, repaired on the next idle cycle.
    int            m_cnt = 0, m_corr = 0;
    bit            m_rd = 0, m_wb = 0, m_unc = 0, m_sweep = 0;
    logic [AW-1:0] m_addr = '0, m_last = '0;
    logic [31:0]   m_wbd = '0;

    task automatic next_word();
        m_sweep = (m_addr == AW'(DEPTH - 1));
        m_addr  = m_addr + 1'b1;
        m_rd    = 0;
        m_wb    = 0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt = 0; m_corr = 0; m_rd = 0; m_wb = 0; m_unc = 0; m_sweep = 0;
            m_addr = '0; m_last = '0; m_wbd = '0;
        end else begin
            m_sweep = 0;
            if (m_wb) begin
                if (cpu_we && cpu_addr == m_addr) next_word();
                else if (!(cpu_re || cpu_we)) begin
                    if (m_corr < (1 << CW) - 1) m_corr++;
                    m_last = m_addr;
                    next_word();
                end
            end else if (m_rd) begin
                if (!(cpu_re || cpu_we)) begin
                    if ($countones(flip[m_addr]) > 1) begin
                        m_unc = 1; m_last = m_addr; next_word();
                    end else if ($countones(flip[m_addr]) == 1) begin
                        m_wbd = golden[m_addr]; m_rd = 0; m_wb = 1;
                    end else next_word();
                end
            end else if (scrub_en) begin
                m_cnt++;
                if (m_cnt == IV) begin m_cnt = 0; m_rd = 1; end
            end
        end
        if (mem_we) wr_count++;
        if (ld) begin
            for (int i = 0; i < DEPTH; i++) begin golden[i] <= pat(i); flip[i] <= '0; end
        end else if (mem_we) begin
            golden[mem_addr] <= mem_wdata;
            flip[mem_addr]   <= '0;
        end
        if (inj) flip[inj_a] <= inj_m;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; ld = 1'b1; scrub_en = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; inj = 1'b0;
        @(negedge clk); ld = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic inject(input logic [AW-1:0] a, input logic [31:0] m);
        inj = 1'b1; inj_a = a; inj_m = m;
        @(negedge clk); inj = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; ld = 1'b1; scrub_en = 1'b1; cpu_we = 1'b1; cpu_addr = 3'd5; cpu_wdata = 32'hCAFE;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL reset_mem_we got %b want 1", mem_we); end
        checks++; if (mem_addr !== 3'd5) begin errors++; $display("FAIL reset_mem_addr got %0d want 5", mem_addr); end
        checks++; if (scrub_busy !== 1'b0 || sweep_done !== 1'b0 || uncorr_flag !== 1'b0) begin
            errors++; $display("FAIL reset_status got busy=%b sweep=%b unc=%b want 0", scrub_busy, sweep_done, uncorr_flag); end
        checks++; if (corr_cnt !== '0 || last_err_addr !== '0) begin
            errors++; $display("FAIL reset_log got cnt=%0d last=%0d want 0", corr_cnt, last_err_addr); end
        cpu_we = 1'b0; #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we_low got %b want 0", mem_we); end
        @(negedge clk); ld = 1'b0; scrub_en = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_clean_sweep();
        int reads = 0, pulses = 0;
        do_reset();
        scrub_en = 1'b1;
        for (int c = 0; c < 42; c++) begin
            #1;
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clean_mem_we c=%0d got %b want 0", c, mem_we); end
            checks++; if (scrub_busy !== (m_rd || m_wb)) begin errors++; $display("FAIL clean_busy c=%0d got %b want %b", c, scrub_busy, m_rd || m_wb); end
            checks++; if (sweep_done !== m_sweep) begin errors++; $display("FAIL clean_sweep c=%0d got %b want %b", c, sweep_done, m_sweep); end
            if (m_rd) begin
                checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL clean_addr c=%0d got %0d want %0d", c, mem_addr, m_addr); end
            end
            if (scrub_busy === 1'b1) reads++;
            if (sweep_done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (reads != 8) begin errors++; $display("FAIL clean_reads got %0d want 8", reads); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL clean_pulses got %0d want 1", pulses); end
        checks++; if (corr_cnt !== '0 || uncorr_flag !== 1'b0) begin errors++; $display("FAIL clean_status got cnt=%0d unc=%b want 0", corr_cnt, uncorr_flag); end
    endtask

    task automatic test_single_repair();
        int w0, writes = 0;
        bit prev_rd1 = 0;
        do_reset();
        inject(3'd1, 32'h0000_0080);
        w0 = wr_count;
        scrub_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (mem_we !== m_wb) begin errors++; $display("FAIL repair_we c=%0d got %b want %b", c, mem_we, m_wb); end
            if (mem_we === 1'b1) begin
                writes++;
                checks++; if (!prev_rd1) begin errors++; $display("FAIL repair_follow c=%0d got no prior read of 1 want read then write", c); end
                checks++; if (mem_addr !== 3'd1 || mem_wdata !== pat(1)) begin
                    errors++; $display("FAIL repair_data got a=%0d d=%h want a=1 d=%h", mem_addr, mem_wdata, pat(1)); end
            end
            prev_rd1 = (scrub_busy === 1'b1 && mem_addr === 3'd1 && mem_we === 1'b0);
            @(negedge clk);
        end
        checks++; if (writes != 1 || wr_count - w0 != 1) begin errors++; $display("FAIL repair_count got %0d want 1", writes); end
        checks++; if (golden[1] !== pat(1) || flip[1] !== '0) begin errors++; $display("FAIL repair_mem got %h want %h", view(3'd1), pat(1)); end
        checks++; if (corr_cnt !== (LOG ? CW'(1) : CW'(0))) begin errors++; $display("FAIL repair_cnt got %0d want %0d", corr_cnt, LOG); end
        checks++; if (last_err_addr !== (LOG ? 3'd1 : 3'd0)) begin errors++; $display("FAIL repair_last got %0d want %0d", last_err_addr, LOG); end
        checks++; if (uncorr_flag !== 1'b0) begin errors++; $display("FAIL repair_unc got %b want 0", uncorr_flag); end
    endtask

    task automatic test_double_err();
        int w0;
        do_reset();
        inject(3'd2, 32'h0000_0208);
        w0 = wr_count;
        scrub_en = 1'b1;
        for (int c = 0; c < 50; c++) begin
            #1;
            checks++; if (uncorr_flag !== m_unc) begin errors++; $display("FAIL dbl_flag c=%0d got %b want %b", c, uncorr_flag, m_unc); end
            if (c == 20) begin
                checks++; if (last_err_addr !== (LOG ? 3'd2 : 3'd0)) begin errors++; $display("FAIL dbl_last got %0d want %0d", last_err_addr, LOG ? 2 : 0); end
            end
            @(negedge clk);
        end
        checks++; if (uncorr_flag !== 1'b1) begin errors++; $display("FAIL dbl_sticky got %b want 1", uncorr_flag); end
        checks++; if (wr_count != w0) begin errors++; $display("FAIL dbl_nowrite got %0d writes want 0", wr_count - w0); end
    endtask

    task automatic test_contention();
        int n = 0;
        do_reset();
        inject(3'd6, 32'h0001_0000);
        inject(3'd7, 32'h0000_0011);
        scrub_en = 1'b1; #1;
        while (!m_rd && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (!m_rd || scrub_busy !== 1'b1) begin errors++; $display("FAIL cont_reach got busy=%b want 1", scrub_busy); end
        for (int c = 0; c < 10; c++) begin
            cpu_re = 1'b1; cpu_addr = (c % 2 == 0) ? 3'd6 : 3'(4 + $urandom_range(0, 3)); #1;
            checks++; if (mem_addr !== cpu_addr || mem_we !== 1'b0) begin errors++; $display("FAIL cont_addr c=%0d got %0d we=%b want %0d", c, mem_addr, mem_we, cpu_addr); end
            checks++; if (cpu_rdata !== view(cpu_addr)) begin errors++; $display("FAIL cont_rdata c=%0d got %h want %h", c, cpu_rdata, view(cpu_addr)); end
            checks++; if (scrub_busy !== 1'b1) begin errors++; $display("FAIL cont_hold c=%0d got %b want 1", c, scrub_busy); end
            @(negedge clk);
        end
        cpu_re = 1'b0; #1;
        checks++; if (mem_addr !== 3'd0 || scrub_busy !== 1'b1) begin errors++; $display("FAIL cont_sample got a=%0d busy=%b want a=0 busy=1", mem_addr, scrub_busy); end
        @(negedge clk); #1;
        checks++; if (scrub_busy !== 1'b0 || uncorr_flag !== 1'b0) begin errors++; $display("FAIL cont_done got busy=%b unc=%b want 0 0", scrub_busy, uncorr_flag); end
    endtask

    task automatic test_stale_cancel();
        int n = 0, w0;
        do_reset();
        inject(3'd1, 32'h0000_0010);
        w0 = wr_count;
        scrub_en = 1'b1; #1;
        while (!m_wb && n < 30) begin @(negedge clk); #1; n++; end
        checks++; if (!m_wb || scrub_busy !== 1'b1) begin errors++; $display("FAIL stale_reach got busy=%b want 1", scrub_busy); end
        cpu_we = 1'b1; cpu_addr = 3'd1; cpu_wdata = 32'h12; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 3'd1 || mem_wdata !== 32'h12) begin
            errors++; $display("FAIL stale_port got we=%b a=%0d d=%h want 1 1 12", mem_we, mem_addr, mem_wdata); end
        @(negedge clk); cpu_we = 1'b0; #1;
        checks++; if (golden[1] !== 32'h12 || wr_count - w0 != 1) begin errors++; $display("FAIL stale_mem got %h writes=%0d want 12 1", golden[1], wr_count - w0); end
        checks++; if (corr_cnt !== '0 || scrub_busy !== 1'b0) begin errors++; $display("FAIL stale_cnt got cnt=%0d busy=%b want 0 0", corr_cnt, scrub_busy); end
        n = 0;
        while (!m_rd && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (mem_addr !== 3'd2 || scrub_busy !== 1'b1) begin errors++; $display("FAIL stale_next got a=%0d busy=%b want 2 1", mem_addr, scrub_busy); end
    endtask

    task automatic test_reset_in_wb();
        int n = 0, w0;
        do_reset();
        inject(3'd0, 32'h0000_0004);
        scrub_en = 1'b1; #1;
        while (!m_wb && n < 30) begin @(negedge clk); #1; n++; end
        checks++; if (!m_wb || scrub_busy !== 1'b1) begin errors++; $display("FAIL rstwb_reach got busy=%b want 1", scrub_busy); end
        w0 = wr_count;
        rst = 1'b0; #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstwb_we got %b want 0", mem_we); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (wr_count != w0 || flip[0] !== 32'h4) begin errors++; $display("FAIL rstwb_nowrite got writes=%0d want 0", wr_count - w0); end
        checks++; if (scrub_busy !== 1'b0 || uncorr_flag !== 1'b0 || corr_cnt !== '0 || last_err_addr !== '0 || sweep_done !== 1'b0) begin
            errors++; $display("FAIL rstwb_status got busy=%b unc=%b cnt=%0d last=%0d want 0", scrub_busy, uncorr_flag, corr_cnt, last_err_addr); end
        n = 0;
        while (!m_rd && n < 20) begin @(negedge clk); #1; n++; end
        checks++; if (mem_addr !== 3'd0 || scrub_busy !== 1'b1) begin errors++; $display("FAIL rstwb_restart got a=%0d busy=%b want 0 1", mem_addr, scrub_busy); end
    endtask

    task automatic test_random();
        int r, b1;
        bit act, ewe;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            scrub_en = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 3);
            cpu_re = (r == 2); cpu_we = (r == 3);
            cpu_addr = AW'($urandom); cpu_wdata = $urandom;
            inj = ($urandom_range(0, 15) == 0); inj_a = AW'($urandom);
            r = $urandom_range(0, 2); b1 = $urandom_range(0, 31);
            inj_m = '0;
            if (r >= 1) inj_m[b1] = 1'b1;
            if (r == 2) inj_m[(b1 + 1 + $urandom_range(0, 30)) % 32] = 1'b1;
            #1;
            act = cpu_re | cpu_we;
            ewe = act ? cpu_we : (rst && m_wb);
            checks++; if (scrub_busy !== (m_rd || m_wb)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, scrub_busy, m_rd || m_wb); end
            checks++; if (sweep_done !== m_sweep) begin errors++; $display("FAIL rnd_sweep c=%0d got %b want %b", c, sweep_done, m_sweep); end
            checks++; if (uncorr_flag !== m_unc) begin errors++; $display("FAIL rnd_unc c=%0d got %b want %b", c, uncorr_flag, m_unc); end
            checks++; if (corr_cnt !== (LOG ? CW'(m_corr) : CW'(0))) begin errors++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, corr_cnt, LOG ? m_corr : 0); end
            checks++; if (last_err_addr !== (LOG ? m_last : 3'd0)) begin errors++; $display("FAIL rnd_last c=%0d got %0d want %0d", c, last_err_addr, LOG ? m_last : 3'd0); end
            checks++; if (mem_we !== ewe) begin errors++; $display("FAIL rnd_we c=%0d got %b want %b", c, mem_we, ewe); end
            checks++; if (cpu_rdata !== view(mem_addr)) begin errors++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, cpu_rdata, view(mem_addr)); end
            if (act || m_rd || m_wb) begin
                checks++; if (mem_addr !== (act ? cpu_addr : m_addr)) begin errors++; $display("FAIL rnd_addr c=%0d got %0d want %0d", c, mem_addr, act ? cpu_addr : m_addr); end
            end
            if (ewe) begin
                checks++; if (mem_wdata !== (act ? cpu_wdata : m_wbd)) begin errors++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, mem_wdata, act ? cpu_wdata : m_wbd); end
            end
            @(negedge clk);
        end
        inj = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_single_repair();
        test_double_err();
        test_contention();
        test_stale_cancel();
        test_reset_in_wb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
